// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I opcodes, fetch FSM encoding and fetch constants.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] C_OP_LW    = 7'b0000011;
    localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] C_OP_SW    = 7'b0100011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_JALR  = 7'b1100111;
    localparam logic [6:0] C_OP_LUI   = 7'b0110111;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/next_pc_gen.sv
// ============================================================================
// Module      : next_pc_gen
// Description : Next-PC mux (jalr > branch/jal > sequential) with alignment flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module next_pc_gen
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    input  logic        pc_src0,
    input  logic        pc_src1,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        if (pc_src1) begin
            next_pc = alu_result & ~32'h1;
        end else if (pc_src0) begin
            next_pc = pc + imm_ext;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule : next_pc_gen

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch over req/gnt/rvalid, holding instr until ready.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             pc_src0,
    input  logic             pc_src1,
    input  logic [31:0]      imm_ext,
    input  logic [31:0]      alu_result,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_count;
    logic [31:0]      w_next_pc;
    logic             w_misaligned;
    logic             w_accept;

    next_pc_gen u_next_pc_gen (
        .pc         (r_pc),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .pc_src0    (pc_src0),
        .pc_src1    (pc_src1),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    // Redirect inputs only matter in the single HOLD cycle that hands off instr.
    assign w_accept = (r_state == ST_HOLD) && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ:  if (imem_gnt) w_state_nxt = ST_WAIT;
            ST_WAIT: if (imem_rvalid) w_state_nxt = ST_HOLD;
            ST_HOLD: if (instr_ready) w_state_nxt = w_misaligned ? ST_ERR : ST_REQ;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= C_NOP;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            if ((r_state == ST_WAIT) && imem_rvalid) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
                if (w_misaligned) begin
                    r_misalign <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ST_HOLD);
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign misalign    = r_misalign;
    assign fetch_count = r_fetch_count;

endmodule : instr_fetch

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src0;
    logic        pc_src1;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;
    int exp_fc = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_src0     (pc_src0),
        .pc_src1     (pc_src1),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Runs one REQ/WAIT transaction and leaves the bench at the first HOLD negedge.
    task automatic fetch_to_hold(input int gd, input int rd, input logic [31:0] data,
                                 output logic [31:0] addr, output int waited);
        waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (imem_req !== 1'b1) begin
            fails++;
            $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
        end
        addr = imem_addr;
        repeat (gd) @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        repeat (rd) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    task automatic accept(input logic s0, input logic s1, input logic [31:0] imm,
                          input logic [31:0] alu);
        pc_src0     = s0;
        pc_src1     = s1;
        imm_ext     = imm;
        alu_result  = alu;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_src0     = 1'b0;
        pc_src1     = 1'b0;
        imm_ext     = 32'h0;
        alu_result  = 32'h0;
        exp_fc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b required 0", imem_req); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
        tests++; if (instr !== 32'h13) begin fails++; $display("FAIL rst_instr: got %h required 00000013", instr); end
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h required 0", pc); end
        tests++; if (pc_plus4 !== 32'h4) begin fails++; $display("FAIL rst_pc_plus4: got %h required 4", pc_plus4); end
        tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b required 0", misalign); end
        tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL rst_count: got %0d required 0", fetch_count); end
        rst = 1'b0;
        exp_fc = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] addr;
        logic [31:0] data;
        int waited;
        for (int i = 0; i < 4; i++) begin
            data = 32'h0010_0093 + 32'(i);
            fetch_to_hold(0, 0, data, addr, waited);
            tests++; if (addr !== 32'(4 * i)) begin fails++; $display("FAIL seq_addr[%0d]: got %h required %h", i, addr, 4 * i); end
            tests++; if (instr !== data || instr_valid !== 1'b1) begin fails++; $display("FAIL seq_instr[%0d]: got %h/%b required %h/1", i, instr, instr_valid, data); end
            if (i > 0) begin
                tests++; if (waited != 0) begin fails++; $display("FAIL seq_throughput[%0d]: got %0d extra cycles required 0", i, waited); end
            end
            accept(1'b0, 1'b0, 32'h0, 32'h0);
            tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin fails++; $display("FAIL seq_after_accept[%0d]: valid=%b req=%b required 0/1", i, instr_valid, imem_req); end
        end
        tests++; if (fetch_count !== 32'd4) begin fails++; $display("FAIL seq_count: got %0d required 4", fetch_count); end
        tests++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL seq_next_addr: got %h required 10", imem_addr); end
    endtask

    task automatic test_branch();
        logic [31:0] addr;
        int waited;
        fetch_to_hold(0, 0, 32'h0000_0063, addr, waited);
        tests++; if (pc !== 32'h10) begin fails++; $display("FAIL br_pc: got %h required 10", pc); end
        accept(1'b1, 1'b0, 32'hFFFF_FFF8, 32'hAAAA_AAAA);
        fetch_to_hold(0, 0, 32'h0000_0067, addr, waited);
        tests++; if (addr !== 32'h08) begin fails++; $display("FAIL br_target: got %h required 8", addr); end
        accept(1'b1, 1'b1, 32'h0000_1234, 32'h0000_0101);
        fetch_to_hold(0, 0, 32'h0000_0013, addr, waited);
        tests++; if (addr !== 32'h100) begin fails++; $display("FAIL jalr_priority: got %h required 100", addr); end
        tests++; if (pc_plus4 !== 32'h104) begin fails++; $display("FAIL jalr_pc_plus4: got %h required 104", pc_plus4); end
        accept(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFD);
        fetch_to_hold(0, 0, 32'h0000_0013, addr, waited);
        tests++; if (addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL top_addr: got %h required fffffffc", addr); end
        accept(1'b0, 1'b0, 32'h0, 32'h0);
        fetch_to_hold(0, 0, 32'h0000_0013, addr, waited);
        tests++; if (addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h required 0", addr); end
        accept(1'b0, 1'b1, 32'h0, 32'h0000_0100);
    endtask

    task automatic test_back_pressure();
        logic [31:0] addr;
        logic [31:0] fc0;
        int waited;
        fetch_to_hold(0, 0, 32'h0030_8093, addr, waited);
        fc0 = fetch_count;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (instr !== 32'h0030_8093 || pc !== 32'h100 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: instr=%h pc=%h valid=%b req=%b required 00308093/100/1/0", k, instr, pc, instr_valid, imem_req);
            end
            @(negedge clk);
        end
        accept(1'b0, 1'b0, 32'h0, 32'h0);
        tests++; if (fetch_count !== fc0 + 32'd1) begin fails++; $display("FAIL bp_count: got %0d required %0d", fetch_count, fc0 + 32'd1); end
        tests++; if (pc !== 32'h104 || imem_req !== 1'b1) begin fails++; $display("FAIL bp_release: pc=%h req=%b required 104/1", pc, imem_req); end
    endtask

    task automatic test_delays();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
                fails++;
                $display("FAIL dly_req_hold[%0d]: req=%b addr=%h required 1/104", k, imem_req, imem_addr);
            end
            imem_rvalid = (k == 1);
            imem_rdata  = (k == 1) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        tests++; if (imem_req !== 1'b1 || instr !== 32'h0030_8093) begin fails++; $display("FAIL dly_spurious: req=%b instr=%h required 1/00308093", imem_req, instr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL dly_wait[%0d]: req=%b valid=%b required 0/0", k, imem_req, instr_valid);
            end
            @(negedge clk);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0040_0113;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        tests++; if (instr !== 32'h0040_0113 || instr_valid !== 1'b1 || pc !== 32'h104) begin fails++; $display("FAIL dly_capture: instr=%h valid=%b pc=%h required 00400113/1/104", instr, instr_valid, pc); end
        accept(1'b0, 1'b1, 32'h0, 32'h0000_0020);
    endtask

    task automatic test_misalign();
        logic [31:0] addr;
        int waited;
        fetch_to_hold(0, 0, 32'h0000_0013, addr, waited);
        tests++; if (pc !== 32'h20) begin fails++; $display("FAIL mis_pc_before: got %h required 20", pc); end
        accept(1'b1, 1'b0, 32'h0000_0002, 32'h0);
        tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL mis_flag: got %b required 1", misalign); end
        tests++; if (fetch_count !== 32'(exp_fc)) begin fails++; $display("FAIL mis_count: got %0d required %0d", fetch_count, exp_fc); end
        for (int k = 0; k < 4; k++) begin
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b1;
            instr_ready = 1'b1;
            @(negedge clk);
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h20 || misalign !== 1'b1) begin
            fails++;
            $display("FAIL mis_terminal: req=%b valid=%b pc=%h mis=%b required 0/0/20/1", imem_req, instr_valid, pc, misalign);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] addr;
        int waited;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_fc = 0;
        fetch_to_hold(0, 0, 32'h0000_0013, addr, waited);
        accept(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL mid_setup: req=%b addr=%h required 1/40", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (pc !== 32'h0 || instr !== 32'h13 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 32'h0 || misalign !== 1'b0) begin
            fails++;
            $display("FAIL mid_async_reset: pc=%h instr=%h req=%b valid=%b cnt=%0d mis=%b required 0/13/0/0/0/0", pc, instr, imem_req, instr_valid, fetch_count, misalign);
        end
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h13) begin
            fails++;
            $display("FAIL mid_stale: req=%b addr=%h instr=%h required 1/0/13", imem_req, imem_addr, instr);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        fetch_to_hold(0, 0, 32'h00A0_0093, addr, waited);
        tests++; if (addr !== 32'h0 || instr !== 32'h00A0_0093) begin fails++; $display("FAIL mid_refetch: addr=%h instr=%h required 0/00a00093", addr, instr); end
    endtask

    initial begin
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        pc_src0     = 1'b0;
        pc_src1     = 1'b0;
        imm_ext     = 32'h0;
        alu_result  = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_back_pressure();
        test_delays();
        test_misalign();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_instr_fetch

`default_nettype wire
